// File: rtl/trace_packer.sv
// Logic-analyser style trace packer: packs 1..MAX_TRACES lanes per cycle into
// WIDTH-bit words and stops DELAY_I full words after the word holding the trigger.
//
// state     | meaning
// IDLE      | not capturing; flags and any pending output word are held
// ARMED     | capturing lanes, waiting for FPGA_TRIG_I
// TRIGGERED | capturing, counting completed words down to the stop point
// DONE      | capture halted, FPGA_TRIG_O high, pending word may still drain
module trace_packer #(
  parameter int WIDTH      = 64,
  parameter int MAX_TRACES = 8,
  parameter int DELAY_BITS = 16
) (
  input  logic                          FPGA_CLK_I,
  input  logic                          RST_NI,
  input  logic                          EN_I,
  input  logic [$clog2(MAX_TRACES):0]   NTRACE_I,
  input  logic [DELAY_BITS-1:0]         DELAY_I,
  input  logic                          FPGA_TRIG_I,
  input  logic [MAX_TRACES-1:0]         FPGA_TRACE_I,
  output logic [WIDTH-1:0]              DATA_O,
  output logic                          VALID_O,
  input  logic                          READY_I,
  output logic [$clog2(WIDTH)-1:0]      EVENT_POS_O,
  output logic                          TRG_EVENT_O,
  output logic                          FPGA_TRIG_O,
  output logic                          OVERFLOW_O
);

  localparam int PW     = $clog2(WIDTH);
  localparam int LOG_MT = $clog2(MAX_TRACES);
  localparam int LW     = LOG_MT + 1;

  typedef enum logic [1:0] {IDLE, ARMED, TRIGGERED, DONE} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         lanes_log_q, lanes_log_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic [WIDTH-1:0]      pack_q, pack_d;
  logic [DELAY_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  valid_q, valid_d;
  logic [PW-1:0]         event_pos_q, event_pos_d;
  logic                  trg_event_q, trg_event_d;
  logic                  overflow_q, overflow_d;

  logic [PW:0]           lanes_w;
  logic [PW:0]           last_pos;
  logic                  capture;
  logic                  word_done;
  logic [PW-1:0]         idx;

  assign lanes_w   = (PW+1)'(1) << lanes_log_q;
  assign last_pos  = (PW+1)'(WIDTH) - lanes_w;
  assign capture   = EN_I && ((state_q == ARMED) || (state_q == TRIGGERED));
  assign word_done = capture && ({1'b0, pos_q} == last_pos);

  always_ff @(posedge FPGA_CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q     <= IDLE;
      lanes_log_q <= '0;
      pos_q       <= '0;
      pack_q      <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      event_pos_q <= '0;
      trg_event_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lanes_log_q <= lanes_log_d;
      pos_q       <= pos_d;
      pack_q      <= pack_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      event_pos_q <= event_pos_d;
      trg_event_q <= trg_event_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lanes_log_d = lanes_log_q;
    pos_d       = pos_q;
    pack_d      = pack_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    event_pos_d = event_pos_q;
    trg_event_d = trg_event_q;
    overflow_d  = overflow_q;
    idx         = '0;

    // The handshake runs in every state so a pending word always drains.
    if (valid_q && READY_I) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (EN_I) begin
          state_d     = ARMED;
          lanes_log_d = (NTRACE_I > LW'(LOG_MT)) ? LW'(LOG_MT) : NTRACE_I;
          pos_d       = '0;
          event_pos_d = '0;
          trg_event_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      ARMED, TRIGGERED: begin
        if (!EN_I) begin
          state_d = IDLE;
          pos_d   = '0;
        end else begin
          for (int i = 0; i < MAX_TRACES; i++) begin
            if (i < int'(lanes_w)) begin
              idx         = pos_q + PW'(i);
              pack_d[idx] = FPGA_TRACE_I[i];
            end
          end
          pos_d = word_done ? '0 : pos_q + lanes_w[PW-1:0];

          if (word_done) begin
            if (!valid_q || READY_I) begin
              data_d  = pack_d;
              valid_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end

          // A trigger landing on the completing cycle already counts that word.
          if ((state_q == ARMED) && FPGA_TRIG_I) begin
            event_pos_d = pos_q;
            trg_event_d = 1'b1;
            state_d     = TRIGGERED;
            cnt_d       = DELAY_I;
            if (word_done) begin
              if (DELAY_I == '0) state_d = DONE;
              else               cnt_d   = DELAY_I - DELAY_BITS'(1);
            end
          end else if ((state_q == TRIGGERED) && word_done) begin
            if (cnt_q == '0) state_d = DONE;
            else             cnt_d   = cnt_q - DELAY_BITS'(1);
          end
        end
      end
      DONE: begin
        if (!EN_I) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign DATA_O      = data_q;
  assign VALID_O     = valid_q;
  assign EVENT_POS_O = event_pos_q;
  assign TRG_EVENT_O = trg_event_q;
  assign FPGA_TRIG_O = (state_q == DONE);
  assign OVERFLOW_O  = overflow_q;

endmodule

// File: doc/trace_packer.md
TRACE_PACKER -- requirements
Module: trace_packer

Interface
REQ-001 Parameter WIDTH, 64, memory word width in bits; power of two, >= MAX_TRACES.
REQ-002 Parameter MAX_TRACES, 8, maximum trace lanes captured per cycle; power of two.
REQ-003 Parameter DELAY_BITS, 16, width of post-trigger word counter.
REQ-004 Port FPGA_CLK_I  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port RST_NI  in  1  asynchronous, active-low reset.
REQ-006 Port EN_I  in  1  capture enable; low forces IDLE.
REQ-007 Port NTRACE_I  in  $clog2(MAX_TRACES)+1  log2 of active lanes; lanes = 2**min(NTRACE_I, $clog2(MAX_TRACES)).
REQ-008 Port DELAY_I  in  DELAY_BITS  number of full words emitted after the word containing the trigger.
REQ-009 Port FPGA_TRIG_I  in  1  trigger input.
REQ-010 Port FPGA_TRACE_I  in  MAX_TRACES  trace lanes; lane i at bit i.
REQ-011 Port DATA_O  out  WIDTH  packed trace word.
REQ-012 Port VALID_O  out  1  DATA_O holds an unaccepted word.
REQ-013 Port READY_I  in  1  memory side accepts DATA_O when VALID_O & READY_I.
REQ-014 Port EVENT_POS_O  out  $clog2(WIDTH)  bit position of trigger within its word.
REQ-015 Port TRG_EVENT_O  out  1  trigger seen since arming (sticky).
REQ-016 Port FPGA_TRIG_O  out  1  high in DONE; delayed trigger for daisy-chaining.
REQ-017 Port OVERFLOW_O  out  1  sticky; a completed word was dropped.

Function
REQ-018 States IDLE, ARMED, TRIGGERED, DONE; IDLE->ARMED the cycle after EN_I is sampled high in IDLE.
REQ-019 Any state with EN_I low -> IDLE next cycle; partial word and pos discarded, pending VALID_O word retained until accepted.
REQ-020 Lane count latched at IDLE->ARMED; NTRACE_I changes ignored until next IDLE.
REQ-021 In ARMED/TRIGGERED each cycle: FPGA_TRACE_I[lanes-1:0] written to packing bits [pos +: lanes]; pos += lanes, wrapping to 0 after pos == WIDTH-lanes (word complete).
REQ-022 No capture in IDLE or DONE; first capture is the first ARMED cycle, at pos 0.
REQ-023 Word complete and (VALID_O low or READY_I high): completed word including the current cycle's lanes loaded into DATA_O, VALID_O high next cycle.
REQ-024 Word complete while VALID_O high and READY_I low: word dropped, OVERFLOW_O set, DATA_O unchanged, packing continues at pos 0.
REQ-025 DATA_O stable while VALID_O high; VALID_O clears after accept unless a new word loads the same cycle.
REQ-026 FPGA_TRIG_I high in ARMED: EVENT_POS_O <= pos of that cycle, TRG_EVENT_O <= 1, cnt <= DELAY_I, state -> TRIGGERED; later triggers ignored until IDLE.
REQ-027 Word completion in TRIGGERED, or in the trigger cycle itself: cnt == 0 -> DONE, else cnt <= cnt-1; total words emitted from trigger word onward = DELAY_I+1.
REQ-028 Dropped words (REQ-024) still count toward REQ-027.
REQ-029 DONE: FPGA_TRIG_O high, capture halted, VALID_O/READY_I handshake still completes pending word.
REQ-030 TRG_EVENT_O, EVENT_POS_O, OVERFLOW_O cleared on IDLE->ARMED; held through DONE and IDLE.

Reset
REQ-031 RST_NI low asynchronously forces: state IDLE, pos 0, cnt 0, DATA_O 0, VALID_O 0, EVENT_POS_O 0, TRG_EVENT_O 0, FPGA_TRIG_O 0, OVERFLOW_O 0.
REQ-032 Reset mid-handshake discards the pending word; no accept counted; deassertion resumes in IDLE.

Verification (WIDTH=64, MAX_TRACES=8)
REQ-033 NTRACE_I=3, READY_I=1, trace byte k=k for 8 cycles -> one word 0x0706050403020100, VALID_O 1 cycle.
REQ-034 NTRACE_I=0, FPGA_TRIG_I at capture cycle 10, DELAY_I=2 -> EVENT_POS_O=10, 3 words emitted, FPGA_TRIG_O high after third, no further VALID_O.
REQ-035 NTRACE_I=3, READY_I=0 for 20 cycles -> first word held on DATA_O, OVERFLOW_O=1 from cycle 16 completion, DATA_O unchanged.
REQ-036 Trigger on word-completion cycle with DELAY_I=0 -> DONE next cycle, exactly one word emitted.
REQ-037 EN_I dropped at pos 24 then raised -> next word starts at pos 0, flags cleared on re-arm, NTRACE_I change honoured.
REQ-038 RST_NI pulsed low while VALID_O=1 -> all outputs 0 immediately, no clock edge required.
